// File: rtl/clc_flag.sv
// Song-change detector: pulses cnt_clc1 for PULSE_LEN cycles whenever music_reg changes.
// Latency: one registered cycle from the edge that samples the change to cnt_clc1 high.
// Backpressure: none; this is a free-running monitor, and a change during a pulse retriggers it.
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   music_reg current song-select code (synchronous to clk)
//   cnt_clc1  registered clear flag for the downstream note/beat counters
//
// PULSE_LEN must be in 1..255 and must fit in CNT_W bits (2**CNT_W > PULSE_LEN).
module clc_flag #(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] music_reg,
    output logic             cnt_clc1
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // The counter is loaded with PULSE_LEN-1 on the change edge. That edge
    // already accounts for one high cycle, and counting down to zero
    // accounts for the remaining PULSE_LEN-1 cycles.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

    state_t             state;
    logic [SEL_W-1:0]   prev_sel;
    logic               primed;
    logic [CNT_W-1:0]   pulse_cnt;
    logic               sel_change;

    // Qualified by primed: the first edge after reset only captures the
    // selection, so a power-up value is never reported as a song change.
    // The comparison only feeds register inputs, so music_reg has no
    // combinational path to cnt_clc1.
    assign sel_change = primed && (music_reg != prev_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev_sel  <= '0;
            primed    <= 1'b0;
            pulse_cnt <= '0;
            cnt_clc1  <= 1'b0;
        end else begin
            if (!primed) begin
                prev_sel <= music_reg;
                primed   <= 1'b1;
            end else if (sel_change) begin
                prev_sel <= music_reg;
            end

            case (state)
                IDLE: begin
                    if (sel_change) begin
                        state     <= CLEAR;
                        pulse_cnt <= RELOAD;
                        cnt_clc1  <= 1'b1;
                    end else begin
                        cnt_clc1  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (sel_change) begin
                        // A retrigger extends the pulse to PULSE_LEN cycles past the latest change.
                        pulse_cnt <= RELOAD;
                        cnt_clc1  <= 1'b1;
                    end else if (pulse_cnt == '0) begin
                        state     <= IDLE;
                        cnt_clc1  <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                        cnt_clc1  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt_clc1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clc_flag.sv
// Testbench for clc_flag. Two instances (PULSE_LEN=1 and PULSE_LEN=4) share the stimulus.
// A reference model tracks the number of edges since the last detected change.
// Directed scenarios run first, followed by randomized selections with occasional resets.
module tb_clc_flag;

    logic       clk;
    logic       rst_n;
    logic [1:0] music_reg;
    logic       flag_p1;
    logic       flag_p4;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic       m_primed;
    logic [1:0] m_prev;
    logic       m_seen;
    int         m_since;

    clc_flag #(.SEL_W(2), .PULSE_LEN(1), .CNT_W(8)) u_dut_p1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .music_reg (music_reg),
        .cnt_clc1  (flag_p1)
    );

    clc_flag #(.SEL_W(2), .PULSE_LEN(4), .CNT_W(8)) u_dut_p4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .music_reg (music_reg),
        .cnt_clc1  (flag_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // The output is high while fewer than plen edges have elapsed since the last change edge.
    function automatic logic exp_flag(input int plen);
        return rst_n && m_seen && (m_since < plen);
    endfunction

    task automatic model_reset();
        m_primed = 1'b0;
        m_prev   = 2'd0;
        m_seen   = 1'b0;
        m_since  = 0;
    endtask

    task automatic model_edge();
        if (!m_primed) begin
            m_primed = 1'b1;
            m_prev   = music_reg;
            if (m_since < 1000) m_since++;
        end else if (music_reg != m_prev) begin
            m_prev  = music_reg;
            m_seen  = 1'b1;
            m_since = 0;
        end else begin
            if (m_since < 1000) m_since++;
        end
    endtask

    // Drive the selection mid-cycle, let one rising edge pass, then check both instances.
    task automatic step(input logic [1:0] sel, input string tag);
        @(negedge clk);
        music_reg = sel;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check({tag, "_p1"}, flag_p1, exp_flag(1));
        check({tag, "_p4"}, flag_p4, exp_flag(4));
    endtask

    task automatic hold(input int n, input string tag);
        for (int i = 0; i < n; i++) step(music_reg, tag);
    endtask

    // Assert reset mid-cycle and check that both flags drop at once. Release it
    // just after a rising edge, so that the next step sees the priming edge.
    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_p1", flag_p1, 1'b0);
        check("async_rst_p4", flag_p4, 1'b0);
        for (int i = 0; i < n; i++) step(music_reg, "in_rst");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        music_reg = 2'd1;
        model_reset();
        #1;
        check("rst_p1", flag_p1, 1'b0);
        check("rst_p4", flag_p4, 1'b0);
        hold(2, "rst_hold");
        #1;
        rst_n = 1'b1;

        // Priming edge and a steady selection of 1.
        hold(10, "prime");
        // Single change 1->2.
        step(2'd2, "chg_1_2");
        hold(5, "after_chg");
        // Rewriting the same value must not pulse.
        step(2'd2, "same_val");
        step(2'd2, "same_val");
        hold(4, "same_val_hold");
        // Sequence 2->3->2->1 with changes four cycles apart.
        step(2'd3, "seq_3");  hold(3, "seq_gap");
        step(2'd2, "seq_2");  hold(3, "seq_gap");
        step(2'd1, "seq_1");  hold(6, "seq_tail");
        // Retrigger: 1->2, then 2->3 two cycles later.
        step(2'd2, "retrig_a");
        step(2'd2, "retrig_mid");
        step(2'd3, "retrig_b");
        hold(8, "retrig_tail");
        // Code 0 is a normal selection.
        step(2'd0, "to_zero");
        hold(5, "zero_tail");
        // Reset during a pulse, followed by priming with a new value and then a change.
        step(2'd2, "pre_rst");
        step(2'd2, "pre_rst");
        pulse_reset(2);
        step(2'd1, "reprime");
        hold(3, "reprime_hold");
        step(2'd3, "post_rst_chg");
        hold(6, "post_rst_tail");

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 99) < 35) begin
                step(2'($urandom_range(0, 3)), "rand_sel");
            end else begin
                step(music_reg, "rand_hold");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
